// File: rtl/collision_edge_collector_if.sv
// Pixel-stream bus between the bitmap drawing objects and the collision collector.
// bgdDR qualifies HitEdgeCode in the same cycle; the collector never stalls the stream.
interface collision_edge_collector_if #(
  parameter int EDGE_BITS   = 4,
  parameter int COUNT_WIDTH = 8
);
  logic                   startOfFrame;
  logic                   enable;
  logic                   playerDR;
  logic                   bgdDR;
  logic [EDGE_BITS-1:0]   HitEdgeCode;
  logic                   collision;
  logic [EDGE_BITS-1:0]   collisionEdges;
  logic [COUNT_WIDTH-1:0] collisionCount;
  logic                   frameValid;

  modport master (
    output startOfFrame, enable, playerDR, bgdDR, HitEdgeCode,
    input  collision, collisionEdges, collisionCount, frameValid
  );

  modport slave (
    input  startOfFrame, enable, playerDR, bgdDR, HitEdgeCode,
    output collision, collisionEdges, collisionCount, frameValid
  );
endinterface

// File: rtl/collision_edge_collector.sv
// Accumulates player/brick overlaps and hit edges over a frame and reports
// one registered collision result in the cycle after each frame start.
module collision_edge_collector #(
  parameter int EDGE_BITS   = 4,
  parameter int MIN_PIXELS  = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  collision_edge_collector_if.slave     bus,
  output logic [1:0]                    dbg_state
);
  localparam int PIX_W = $clog2(MIN_PIXELS + 1);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPORT = 2'd2} state_t;

  state_t               state;
  logic [EDGE_BITS-1:0] edge_acc;
  logic [PIX_W-1:0]     pix_cnt;
  logic                 overlap;
  logic                 hit;

  assign overlap   = bus.playerDR & bus.bgdDR & bus.enable & ~bus.startOfFrame;
  assign hit       = (pix_cnt >= PIX_MAX);
  assign dbg_state = state;

  // The report is registered on the startOfFrame edge, so the REPORT state is
  // the cycle in which collision is visible; it accumulates exactly like SCAN.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      edge_acc           <= '0;
      pix_cnt            <= '0;
      bus.collision      <= 1'b0;
      bus.collisionEdges <= '0;
      bus.collisionCount <= '0;
      bus.frameValid     <= 1'b0;
    end else begin
      bus.collision <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.startOfFrame) begin
            edge_acc <= '0;
            pix_cnt  <= '0;
            state    <= SCAN;
          end
        end
        SCAN, REPORT: begin
          if (bus.startOfFrame) begin
            bus.collision      <= hit;
            bus.collisionEdges <= hit ? edge_acc : '0;
            if (hit && (bus.collisionCount != '1))
              bus.collisionCount <= bus.collisionCount + 1'b1;
            bus.frameValid     <= 1'b1;
            edge_acc           <= '0;
            pix_cnt            <= '0;
            state              <= REPORT;
          end else begin
            if (overlap) begin
              edge_acc <= edge_acc | bus.HitEdgeCode;
              if (pix_cnt != PIX_MAX)
                pix_cnt <= pix_cnt + 1'b1;
            end
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
